mod_sub_serial: RTL and testbench



---
 rtl/ntt_pkg.sv | 20 ++
 rtl/half_subtractor.sv | 14 +
 rtl/mod_sub_serial.sv | 134 +++++++++++++
 tb/tb_mod_sub_serial.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
`default_nettype none
// ntt_pkg: shared NTT datapath definitions: serial subtractor states, default modulus/width, counter sizing.
package ntt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    CORR = 2'd2
  } state_t;

  localparam int NTT_Q     = 3329;
  localparam int NTT_WIDTH = 12;

  // Bit counter must reach WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/half_subtractor.sv
`default_nettype none
// half_subtractor: one-bit a - b; two of these plus an OR form a full subtractor.
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic diff,
  output logic borrow
);

  assign diff   = a ^ b;
  assign borrow = ~a & b;

endmodule
`default_nettype wire

// File: rtl/mod_sub_serial.sv
`default_nettype none
// mod_sub_serial: bit-serial (a - b) mod Q, LSB first, one bit per clock, with a serial +Q correction pass.
// Build option MOD_SUB_CONST_TIME_EN always runs the correction pass (adding 0 when no borrow) for fixed latency.
module mod_sub_serial
  import ntt_pkg::*;
#(
  parameter int WIDTH = NTT_WIDTH,
  parameter int Q     = NTT_Q
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] SUB_END  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CORR_END = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] Q_VEC    = WIDTH'(Q);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic             bor, cry;
  logic [CNT_W-1:0] cnt;

  logic hs0_diff, hs0_bor, hs1_diff, hs1_bor;
  logic bor_nx;
  logic sum_bit, cry_nx;

  half_subtractor u_hs0 (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .diff   (hs0_diff),
    .borrow (hs0_bor)
  );

  half_subtractor u_hs1 (
    .a      (hs0_diff),
    .b      (bor),
    .diff   (hs1_diff),
    .borrow (hs1_bor)
  );

  assign bor_nx = hs0_bor | hs1_bor;

  // In CORR, a_sh is reused as the addend shift register.
  assign sum_bit = res[0] ^ a_sh[0] ^ cry;
  assign cry_nx  = (res[0] & a_sh[0]) | (cry & (res[0] ^ a_sh[0]));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = SUB;
      SUB: begin
        if (cnt == SUB_END) begin
`ifdef MOD_SUB_CONST_TIME_EN
          state_nx = CORR;
`else
          state_nx = bor ? CORR : IDLE;
`endif
        end
      end
      CORR:    if (cnt == CORR_END) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      bor  <= 1'b0;
      cry  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
      diff <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh <= a;
            b_sh <= b;
            bor  <= 1'b0;
            cry  <= 1'b0;
            cnt  <= '0;
          end
        end
        SUB: begin
          if (cnt != SUB_END) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            res  <= {hs1_diff, res[WIDTH-1:1]};
            bor  <= bor_nx;
            cnt  <= cnt + CNT_W'(1);
          end else if (state_nx == CORR) begin
            // Borrow means res holds a - b + 2^WIDTH; adding Q wraps it back into range.
            a_sh <= bor ? Q_VEC : '0;
            cry  <= 1'b0;
            cnt  <= '0;
          end else begin
            diff <= res;
            done <= 1'b1;
          end
        end
        CORR: begin
          a_sh <= a_sh >> 1;
          res  <= {sum_bit, res[WIDTH-1:1]};
          cry  <= cry_nx;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CORR_END) begin
            diff <= {sum_bit, res[WIDTH-1:1]};
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mod_sub_serial.sv
`default_nettype none
// tb_mod_sub_serial: directed self-checking bench for the bit-serial modular subtractor.
module tb_mod_sub_serial;

  localparam int WIDTH = 12;
  localparam int Q     = 3329;
`ifdef MOD_SUB_CONST_TIME_EN
  localparam int LAT_NB = 2 * WIDTH + 1;
`else
  localparam int LAT_NB = WIDTH + 1;
`endif
  localparam int LAT_B = 2 * WIDTH + 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a     = '0;
  logic [WIDTH-1:0] b     = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;

  int vectors     = 0;
  int miscompares = 0;

  logic [WIDTH-1:0] tv_a   [6] = '{12'd5, 12'd3,    12'd0, 12'd3328, 12'd0,    12'd1234};
  logic [WIDTH-1:0] tv_b   [6] = '{12'd3, 12'd5,    12'd0, 12'd0,    12'd3328, 12'd1234};
  logic [WIDTH-1:0] tv_exp [6] = '{12'd2, 12'd3327, 12'd0, 12'd3328, 12'd1,    12'd0};
  int               tv_lat [6] = '{LAT_NB, LAT_B,   LAT_NB, LAT_NB,  LAT_B,    LAT_NB};

  mod_sub_serial #(.WIDTH(WIDTH), .Q(Q)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic launch(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output logic [WIDTH-1:0] res,
                           output bit busy_ok, output bit held);
    logic [WIDTH-1:0] prev;
    prev    = diff;
    lat     = -1;
    res     = 'x;
    busy_ok = (busy === 1'b1);
    held    = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = k;
        res = diff;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (diff !== prev) held = 1'b0;
    end
  endtask

  task automatic test_reset;
    vectors++;
    if ({busy, done, diff} !== {1'b0, 1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b diff=%0d, required 0/0/0", busy, done, diff);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, diff} !== {1'b0, 1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b done=%b diff=%0d, required 0/0/0", busy, done, diff);
    end
  endtask

  task automatic test_vectors;
    int               lat;
    logic [WIDTH-1:0] res;
    bit               busy_ok, held;
    for (int i = 0; i < 6; i++) begin
      launch(tv_a[i], tv_b[i]);
      wait_done(lat, res, busy_ok, held);
      vectors++;
      if (res !== tv_exp[i]) begin
        miscompares++;
        $display("FAIL vec%0d diff: a=%0d b=%0d got %0d required %0d", i, tv_a[i], tv_b[i], res, tv_exp[i]);
      end
      vectors++;
      if (lat != tv_lat[i]) begin
        miscompares++;
        $display("FAIL vec%0d latency: got %0d required %0d", i, lat, tv_lat[i]);
      end
      vectors++;
      if (!busy_ok) begin
        miscompares++;
        $display("FAIL vec%0d busy: got irregular busy, required high until done and low at done", i);
      end
      @(negedge clk);
      vectors++;
      if (done !== 1'b0 || diff !== tv_exp[i]) begin
        miscompares++;
        $display("FAIL vec%0d pulse: done=%b diff=%0d, required done=0 diff=%0d", i, done, diff, tv_exp[i]);
      end
    end
  endtask

  task automatic test_ignore_start;
    int               lat;
    logic [WIDTH-1:0] res;
    bit               busy_ok, held;
    bit               extra;
    launch(12'd3, 12'd5);
    repeat (3) @(negedge clk);
    start = 1'b1;
    a     = 12'd100;
    b     = 12'd1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, res, busy_ok, held);
    vectors++;
    if (res !== 12'd3327 || lat != LAT_B - 4) begin
      miscompares++;
      $display("FAIL ignore_start: diff=%0d lat=%0d, required diff=3327 lat=%0d", res, lat, LAT_B - 4);
    end
    extra = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1;
    end
    vectors++;
    if (extra) begin
      miscompares++;
      $display("FAIL ignore_queue: got activity after done, required idle");
    end
  endtask

  task automatic test_back_to_back;
    int               lat;
    logic [WIDTH-1:0] res;
    bit               busy_ok, held;
    launch(12'd5, 12'd3);
    wait_done(lat, res, busy_ok, held);
    vectors++;
    if (res !== 12'd2) begin
      miscompares++;
      $display("FAIL b2b_first: got %0d required 2", res);
    end
    launch(12'd0, 12'd3328);
    wait_done(lat, res, busy_ok, held);
    vectors++;
    if (res !== 12'd1 || lat != LAT_B) begin
      miscompares++;
      $display("FAIL b2b_second: diff=%0d lat=%0d, required diff=1 lat=%0d", res, lat, LAT_B);
    end
    vectors++;
    if (!held || !busy_ok) begin
      miscompares++;
      $display("FAIL b2b_hold: held=%b busy_ok=%b, required 1/1", held, busy_ok);
    end
  endtask

  task automatic test_reset_midop;
    bit saw;
    launch(12'd3, 12'd5);
    repeat (17) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, diff} !== {1'b0, 1'b0, 12'd0}) begin
      miscompares++;
      $display("FAIL reset_midop: busy=%b done=%b diff=%0d, required 0/0/0", busy, done, diff);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || diff !== 12'd0) saw = 1'b1;
    end
    vectors++;
    if (saw) begin
      miscompares++;
      $display("FAIL reset_after: got activity after release, required idle with diff=0");
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_vectors();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
